// File: rtl/bbq_people_counter.sv
// ============================================================================
// Module   : bbq_people_counter (with helper bbq_debounce)
// Brief    : Photocell entry/exit debouncing and saturating queue occupancy
//            counter feeding the wait-time lookup ROM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bbq_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic ev
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [7:0] C_DEB   = 8'(DEB_CYCLES);

  logic [1:0] r_sync;
  logic [1:0] r_fill;
  logic       r_armed;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [7:0] r_dc;
  logic [7:0] w_dc_next;
  logic       w_ev_next;
  logic       w_s;

  assign w_s = r_sync[1];

  // r_armed only sets once a genuine low has passed through the synchroniser,
  // so a beam already blocked across reset must clear before it can count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
      r_state <= ST_IDLE;
      r_dc    <= 8'd0;
      ev      <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], raw};
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~w_s);
      r_state <= w_state_next;
      r_dc    <= w_dc_next;
      ev      <= w_ev_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dc_next    = r_dc;
    case (r_state)
      ST_IDLE: begin
        if (w_s && r_armed) begin
          w_state_next = ST_QUAL;
          w_dc_next    = 8'd1;
        end
      end
      ST_QUAL: begin
        if (!w_s) begin
          w_state_next = ST_IDLE;
          w_dc_next    = 8'd0;
        end else if (r_dc == C_DEB) begin
          w_state_next = ST_HELD;
        end else begin
          w_dc_next = r_dc + 8'd1;
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_next = ST_IDLE;
          w_dc_next    = 8'd0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_dc_next    = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_ev_next = 1'b0;
    if ((r_state == ST_QUAL) && w_s && (r_dc == C_DEB)) w_ev_next = 1'b1;
  end

endmodule

module bbq_people_counter #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_COUNT  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] Tcount,
  output logic [3:0] Pcount,
  output logic       full,
  output logic       empty,
  output logic       reject
);
  localparam logic [3:0] C_MAX = 4'(MAX_COUNT);

  logic w_ev_entry;
  logic w_ev_exit;
  logic w_exit_ok;
  logic w_entry_ok;
  logic w_reject_next;
  logic [3:0] w_pcount_next;

  bbq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_entry (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (entry_sensor),
    .ev    (w_ev_entry)
  );

  bbq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_exit (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (exit_sensor),
    .ev    (w_ev_exit)
  );

  // A simultaneous exit frees a slot, so entry at full is still accepted.
  always_comb begin
    w_exit_ok     = w_ev_exit & (Pcount != 4'd0);
    w_entry_ok    = w_ev_entry & (Tcount != 2'd0) & ((Pcount < C_MAX) | w_exit_ok);
    w_pcount_next = Pcount + {3'b000, w_entry_ok} - {3'b000, w_exit_ok};
    w_reject_next = (w_ev_entry & ~w_entry_ok) | (w_ev_exit & ~w_exit_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Pcount <= 4'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
      reject <= 1'b0;
    end else begin
      Pcount <= w_pcount_next;
      full   <= (w_pcount_next == C_MAX);
      empty  <= (w_pcount_next == 4'd0);
      reject <= w_reject_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bbq_people_counter.sv
// ============================================================================
// Module   : tb_bbq_people_counter
// Brief    : Scoreboard bench for bbq_people_counter with directed pulses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bbq_people_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [1:0] Tcount = 2'd0;
  logic [3:0] Pcount;
  logic       full;
  logic       empty;
  logic       reject;

  typedef struct packed {
    logic [31:0] edge_no;
    logic [3:0]  p;
    logic        f;
    logic        e;
    logic        r;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  logic [3:0] prev_p;
  logic       prev_f, prev_e;

  bbq_people_counter #(.DEB_CYCLES(4), .MAX_COUNT(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .Tcount       (Tcount),
    .Pcount       (Pcount),
    .full         (full),
    .empty        (empty),
    .reject       (reject)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any change of Pcount/full/empty or a reject pulse is an output event.
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      prev_p = Pcount; prev_f = full; prev_e = empty;
    end else begin
      if (Pcount != prev_p || full != prev_f || empty != prev_e || reject) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event edge=%0d got P=%0d f=%b e=%b r=%b, required no event",
                   cyc, Pcount, full, empty, reject);
        end else begin
          x = exp_q.pop_front();
          if (x.edge_no == 32'(cyc) && x.p == Pcount && x.f == full && x.e == empty && x.r == reject)
            passed++;
          else
            $display("FAIL event edge=%0d P=%0d f=%b e=%b r=%b, required edge=%0d P=%0d f=%b e=%b r=%b",
                     cyc, Pcount, full, empty, reject, x.edge_no, x.p, x.f, x.e, x.r);
        end
      end
      prev_p = Pcount; prev_f = full; prev_e = empty;
    end
  end

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] req);
    total++;
    if (got == req) passed++;
    else $display("FAIL %s got=%h required=%h", name, got, req);
  endtask

  // Raise the chosen sensors for n sampled edges, optionally expecting one
  // output event DEB_CYCLES+3 edges after the first high sample.
  task automatic pulse(input logic e, input logic x, input int n, input logic do_push,
                       input logic [3:0] p, input logic f, input logic em, input logic r);
    exp_t ex;
    @(negedge clk);
    entry_sensor = e;
    exit_sensor  = x;
    if (do_push) begin
      ex.edge_no = 32'(cyc + 1 + 7);
      ex.p = p; ex.f = f; ex.e = em; ex.r = r;
      exp_q.push_back(ex);
    end
    repeat (n) @(posedge clk);
    @(negedge clk);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_state", {Pcount, full, empty, reject}, {4'd0, 1'b0, 1'b1, 1'b0});

    Tcount = 2'd1;
    pulse(1, 0, 6, 1, 4'd1, 0, 0, 0);
    pulse(1, 0, 3, 0, 4'd0, 0, 0, 0);
    check("glitch_no_count", {Pcount, full, empty, reject}, {4'd1, 1'b0, 1'b0, 1'b0});
    pulse(1, 0, 50, 1, 4'd2, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd3, 0, 0, 0);

    Tcount = 2'd2;
    pulse(1, 0, 6, 1, 4'd4, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd5, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd6, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd7, 1, 0, 0);
    pulse(1, 0, 6, 1, 4'd7, 1, 0, 1);
    pulse(1, 1, 6, 0, 4'd0, 0, 0, 0);
    check("simul_at_full", {Pcount, full, empty, reject}, {4'd7, 1'b1, 1'b0, 1'b0});

    pulse(0, 1, 6, 1, 4'd6, 0, 0, 0);
    pulse(0, 1, 6, 1, 4'd5, 0, 0, 0);
    pulse(0, 1, 6, 1, 4'd4, 0, 0, 0);
    pulse(0, 1, 6, 1, 4'd3, 0, 0, 0);
    pulse(0, 1, 6, 1, 4'd2, 0, 0, 0);
    pulse(0, 1, 6, 1, 4'd1, 0, 0, 0);
    pulse(0, 1, 6, 1, 4'd0, 0, 1, 0);
    pulse(0, 1, 6, 1, 4'd0, 0, 1, 1);
    pulse(1, 1, 6, 1, 4'd1, 0, 0, 1);
    Tcount = 2'd0;
    pulse(1, 0, 6, 1, 4'd1, 0, 0, 1);
    pulse(0, 1, 6, 1, 4'd0, 0, 1, 0);

    Tcount = 2'd1;
    pulse(1, 0, 6, 1, 4'd1, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd2, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd3, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd4, 0, 0, 0);
    pulse(1, 0, 6, 1, 4'd5, 0, 0, 0);
    check("before_reset", {Pcount, full, empty, reject}, {4'd5, 1'b0, 1'b0, 1'b0});

    // Entry in QUAL when reset hits between edges.
    @(negedge clk);
    entry_sensor = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {Pcount, full, empty, reject}, {4'd0, 1'b0, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("held_through_reset", {Pcount, full, empty, reject}, {4'd0, 1'b0, 1'b1, 1'b0});
    entry_sensor = 1'b0;
    repeat (12) @(negedge clk);
    pulse(1, 0, 6, 1, 4'd1, 0, 0, 0);

    repeat (10) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      total++;
      $display("FAIL missing_event required edge=%0d P=%0d f=%b e=%b r=%b, got none",
               x.edge_no, x.p, x.f, x.e, x.r);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
